mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage, beside the ALU. Executes
//   mult/multu/div/divu and mthi/mtlo. Holds the HI/LO registers that the ALU
//   returns as register data for mfhi/mflo.
//   busy drives the D-stage stall logic for HI/LO-using instructions.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk      in   1   single clock, rising edge
//   reset    in   1   asynchronous, active-low reset (0 = reset)
//   start    in   1   1-cycle request; op/operands valid in the same cycle
//   op       in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   rs_data  in   32  operand A (forwarded RD1); dividend; mthi/mtlo source
//   rt_data  in   32  operand B (forwarded RD2); divisor
//   busy     out  1   1 while a mult/div is in flight
//   hi       out  32  HI register (registered)
//   lo       out  32  LO register (registered)
// BEHAVIOUR
//   Reset: reset=0 forces busy=0, hi=0, lo=0, counter=0 immediately,
//     independent of clk. Any in-flight op is discarded.
//   Cycle 0 means start=1 with op 1-4 and busy=0. At the edge ending cycle 0:
//     - operands are latched and the result is computed into a pending register.
//     - counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
//   Busy window: busy=1 in cycles 1..N. The counter decrements once per cycle.
//   Result commit: at the edge ending cycle N, pending hi/lo are written and the
//     counter reaches 0. busy=0 and the new hi/lo are visible from cycle N+1.
//   mthi/mtlo: if start=1, op is 5 or 6, and busy=0, then hi (or lo) <= rs_data
//     at that edge. The value is visible the next cycle, and busy stays 0.
//   start while busy=1: ignored for every op. There is no queueing, and the
//     in-flight result is not disturbed.
//   start with op 0 or 7: ignored.
//   Arithmetic:
//     - mult: {hi,lo} = $signed(A)*$signed(B), 64-bit.
//     - multu: unsigned 64-bit product.
//     - div: lo = A/B truncated toward zero; hi = remainder with the sign of A.
//     - divu: unsigned quotient in lo, unsigned remainder in hi.
//   Divisor 0 (div/divu): the full busy window still runs. At commit, hi and lo
//     keep their previous values.
//   Signed overflow (div 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
//   Outputs are pure register outputs, with no combinational path from inputs.
//   Reset asserted mid-operation: the result is lost and busy=0 at once. After
//     release, the unit accepts a start on the first edge.
// TESTING
//   1 multu A=0xFFFFFFFF B=2 -> busy=1 for exactly 5 cycles;
//     then hi=0x00000001, lo=0xFFFFFFFE.
//   2 mult A=0xFFFFFFFD(-3) B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 after 5 cycles.
//   3 div A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles;
//     then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also divu 7/2 -> lo=3, hi=1.
//   4 Preload via mthi 0x1234 / mtlo 0x5678 (each visible next cycle, busy=0);
//     then divu B=0 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged.
//   5 multu 3*4 started, then at busy cycle 2 pulse start with op=mtlo,
//     rs=0xAAAA -> ignored; commit gives hi=0, lo=12; busy width stays 5.
//   6 div started, reset=0 in busy cycle 4 with no clk edge -> busy=0, hi=lo=0
//     immediately. After release, mult 2*3 completes normally with lo=6.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/multu/div/divu with HI/LO registers and mthi/mtlo.
// The result is computed when the op is accepted and committed after a fixed busy window.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(NMAX + 1);

  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_pend_we;
  logic [63:0]   r_pend;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic        w_go;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_b_zero;
  logic        w_ovf;
  logic [31:0] w_b_safe;
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [63:0] w_res;

  assign w_go     = i_start && !r_busy && (i_op >= 3'd1) && (i_op <= 3'd4);
  assign w_mthi   = i_start && !r_busy && (i_op == 3'd5);
  assign w_mtlo   = i_start && !r_busy && (i_op == 3'd6);
  assign w_b_zero = (i_rt_data == 32'd0);
  assign w_ovf    = (i_op == 3'd3) && (i_rs_data == 32'h8000_0000) && (i_rt_data == 32'hFFFF_FFFF);
  // Dividing by 1 yields exactly the defined overflow result and keeps /0 free of X
  assign w_b_safe = (w_b_zero || w_ovf) ? 32'd1 : i_rt_data;
  assign w_mul_s  = $signed({{32{i_rs_data[31]}}, i_rs_data}) * $signed({{32{i_rt_data[31]}}, i_rt_data});
  assign w_mul_u  = {32'd0, i_rs_data} * {32'd0, i_rt_data};
  assign w_q_s    = $signed(i_rs_data) / $signed(w_b_safe);
  assign w_r_s    = $signed(i_rs_data) % $signed(w_b_safe);
  assign w_q_u    = i_rs_data / w_b_safe;
  assign w_r_u    = i_rs_data % w_b_safe;
  assign w_res    = (i_op == 3'd1) ? w_mul_s :
                    (i_op == 3'd2) ? w_mul_u :
                    (i_op == 3'd3) ? {w_r_s, w_q_s} : {w_r_u, w_q_u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pend_we <= 1'b0;
      r_pend    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_go) begin
        r_pend    <= w_res;
        r_pend_we <= (i_op <= 3'd2) || !w_b_zero;
        r_cnt     <= (i_op <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          if (r_pend_we) {r_hi, r_lo} <= r_pend;
        end
      end
      if (w_mthi) r_hi <= i_rs_data;
      if (w_mtlo) r_lo <= i_rs_data;
    end
  end

  assign o_busy = r_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven directed vectors plus hand sequences for busy-time start and async reset.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  int total = 0;
  int bad = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op),
    .i_rs_data(rs), .i_rt_data(rt), .o_busy(busy), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  vec_t v[14];
  int n;

  initial begin
    v[0]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
    v[1]  = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    v[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    v[3]  = '{3'd4, 32'd7,         32'd2,        32'd1,         32'd3,         10};
    v[4]  = '{3'd5, 32'h1234,      32'd0,        32'h1234,      32'd3,         0};
    v[5]  = '{3'd6, 32'h5678,      32'd0,        32'h1234,      32'h5678,      0};
    v[6]  = '{3'd4, 32'd99,        32'd0,        32'h1234,      32'h5678,      10};
    v[7]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
    v[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        5};
    v[9]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    v[10] = '{3'd0, 32'hDEAD,      32'hBEEF,     32'd1,         32'hFFFF_FFFD, 0};
    v[11] = '{3'd7, 32'hDEAD,      32'hBEEF,     32'd1,         32'hFFFF_FFFD, 0};
    v[12] = '{3'd3, 32'd5,         32'd0,        32'd1,         32'hFFFF_FFFD, 10};
    v[13] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      count_busy(n);
      chk($sformatf("vec%0d_busy", i), 64'(n), 64'(v[i].n));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(v[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(v[i].lo));
    end

    // mtlo pulsed in busy cycle 2 of a multu must be ignored
    issue(3'd2, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    chk("ign_lo_mid", 64'(lo), 64'd1);
    count_busy(n);
    chk("ign_busy", 64'(n + 2), 64'd5);
    chk("ign_hi", 64'(hi), 64'd0);
    chk("ign_lo", 64'(lo), 64'd12);

    // async reset in busy cycle 4, between edges
    issue(3'd3, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 32'd2, 32'd3);
    count_busy(n);
    chk("post_busy", 64'(n), 64'd5);
    chk("post_hi", 64'(hi), 64'd0);
    chk("post_lo", 64'(lo), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
